// File: rtl/cu_pkg.sv
// Shared definitions for the multi-cycle RV32I control unit.
// Contents: FSM state encoding, RV32I opcode and branch funct3 constants,
// datapath mux encodings (alu_src_a, alu_src_b, result_src, adr_src), and
// the ALU-control / immediate-type codes shared with the ALU decoder.
package cu_pkg;

  localparam int ALU_CNTL_BITS_COUNT = 4;
  localparam int IMM_TYPE_BITS_COUNT = 3;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_MEM_ADR,
    S_MEM_READ,
    S_MEM_WB,
    S_MEM_WRITE,
    S_EXEC_R,
    S_EXEC_I,
    S_ALU_WB,
    S_JAL,
    S_JALR,
    S_UPPER,
    S_BRANCH,
    S_TRAP
  } state_t;

  // RV32I major opcodes
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  // Branch funct3 codes
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Datapath mux encodings
  localparam logic [1:0] SRC_A_PC     = 2'b00;
  localparam logic [1:0] SRC_A_OLDPC  = 2'b01;
  localparam logic [1:0] SRC_A_RS1    = 2'b10;
  localparam logic [1:0] SRC_B_RS2    = 2'b00;
  localparam logic [1:0] SRC_B_IMM    = 2'b01;
  localparam logic [1:0] SRC_B_FOUR   = 2'b10;
  localparam logic [1:0] RES_ALUOUT   = 2'b00;
  localparam logic [1:0] RES_RDATA    = 2'b01;
  localparam logic [1:0] RES_ALU      = 2'b10;
  localparam logic       ADR_PC       = 1'b0;
  localparam logic       ADR_ALUOUT   = 1'b1;

  // ALU operation codes
  localparam logic [ALU_CNTL_BITS_COUNT-1:0] ALU_ADD    = 4'd0;
  localparam logic [ALU_CNTL_BITS_COUNT-1:0] ALU_SUB    = 4'd1;
  localparam logic [ALU_CNTL_BITS_COUNT-1:0] ALU_SLL    = 4'd2;
  localparam logic [ALU_CNTL_BITS_COUNT-1:0] ALU_SLT    = 4'd3;
  localparam logic [ALU_CNTL_BITS_COUNT-1:0] ALU_SLTU   = 4'd4;
  localparam logic [ALU_CNTL_BITS_COUNT-1:0] ALU_XOR    = 4'd5;
  localparam logic [ALU_CNTL_BITS_COUNT-1:0] ALU_SRL    = 4'd6;
  localparam logic [ALU_CNTL_BITS_COUNT-1:0] ALU_SRA    = 4'd7;
  localparam logic [ALU_CNTL_BITS_COUNT-1:0] ALU_OR     = 4'd8;
  localparam logic [ALU_CNTL_BITS_COUNT-1:0] ALU_AND    = 4'd9;
  localparam logic [ALU_CNTL_BITS_COUNT-1:0] ALU_PASS_B = 4'd10;

  // Immediate formats
  localparam logic [IMM_TYPE_BITS_COUNT-1:0] IMM_I = 3'd0;
  localparam logic [IMM_TYPE_BITS_COUNT-1:0] IMM_S = 3'd1;
  localparam logic [IMM_TYPE_BITS_COUNT-1:0] IMM_B = 3'd2;
  localparam logic [IMM_TYPE_BITS_COUNT-1:0] IMM_U = 3'd3;
  localparam logic [IMM_TYPE_BITS_COUNT-1:0] IMM_J = 3'd4;

  function automatic logic [IMM_TYPE_BITS_COUNT-1:0] imm_type_of(input logic [6:0] op);
    case (op)
      OPC_STORE:          imm_type_of = IMM_S;
      OPC_BRANCH:         imm_type_of = IMM_B;
      OPC_LUI, OPC_AUIPC: imm_type_of = IMM_U;
      OPC_JAL:            imm_type_of = IMM_J;
      default:            imm_type_of = IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// ALU decoder: maps funct3, funct7[5] and opcode[5] to an ALU operation.
// Ports:
//   opcode_bit5  in   opcode[5] (1 = register-register, 0 = immediate)
//   funct3       in   instruction funct3
//   funct7_bit5  in   instruction bit 30
//   alu_control  out  ALU operation code
module alu_decoder
  import cu_pkg::*;
(
  input  logic                           opcode_bit5,
  input  logic [2:0]                     funct3,
  input  logic                           funct7_bit5,
  output logic [ALU_CNTL_BITS_COUNT-1:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (funct3)
      // SUB only exists for R-type; addi with bit 30 set is still an add.
      3'b000:  alu_control = (opcode_bit5 && funct7_bit5) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_control = ALU_SLL;
      3'b010:  alu_control = ALU_SLT;
      3'b011:  alu_control = ALU_SLTU;
      3'b100:  alu_control = ALU_XOR;
      3'b101:  alu_control = funct7_bit5 ? ALU_SRA : ALU_SRL;
      3'b110:  alu_control = ALU_OR;
      3'b111:  alu_control = ALU_AND;
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/branch_resolver.sv
// Branch resolver: combinational taken/illegal decision for RV32I branches.
// Ports:
//   funct3     in   branch condition code
//   zero_flag  in   ALU result == 0 (rs1 - rs2)
//   lt_flag    in   signed rs1 < rs2
//   ltu_flag   in   unsigned rs1 < rs2
//   taken      out  branch condition holds
//   illegal    out  funct3 is not a branch condition (010/011)
module branch_resolver
  import cu_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       zero_flag,
  input  logic       lt_flag,
  input  logic       ltu_flag,
  output logic       taken,
  output logic       illegal
);

  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    case (funct3)
      F3_BEQ:  taken = zero_flag;
      F3_BNE:  taken = ~zero_flag;
      F3_BLT:  taken = lt_flag;
      F3_BGE:  taken = ~lt_flag;
      F3_BLTU: taken = ltu_flag;
      F3_BGEU: taken = ~ltu_flag;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control unit. A Moore-style FSM sequences
// fetch / decode / execute / memory / writeback over a shared datapath with a
// single memory port guarded by a request/ready handshake and an optional
// timeout. Illegal instructions and bus timeouts enter a sticky TRAP state.
//
// Optional feature: define MULTICYCLE_CU_PERF_EN to add cycle_count and
// instret_count performance counters.
//
// Ports:
//   clk, reset             clock (rising edge), asynchronous active-high reset
//   opcode/funct3/funct7_bit5  instruction register fields
//   zero_flag/lt_flag/ltu_flag ALU comparison flags
//   mem_ready              memory completes the current request
//   mem_req/mem_write/adr_src  memory request controls
//   ir_write/pc_write/reg_write  architectural write enables
//   alu_src_a/alu_src_b/result_src  datapath mux selects
//   alu_control/imm_type   ALU operation and immediate format
//   illegal_instr/bus_error  sticky trap causes
//   cycle_count/instret_count  (perf build only) 32-bit counters
module multicycle_control_unit
  import cu_pkg::*;
#(
  parameter  int MEM_TIMEOUT = 16,
  localparam int TMO_W       = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [6:0]                     opcode,
  input  logic [2:0]                     funct3,
  input  logic                           funct7_bit5,
  input  logic                           zero_flag,
  input  logic                           lt_flag,
  input  logic                           ltu_flag,
  input  logic                           mem_ready,
  output logic                           mem_req,
  output logic                           mem_write,
  output logic                           adr_src,
  output logic                           ir_write,
  output logic                           pc_write,
  output logic                           reg_write,
  output logic [1:0]                     alu_src_a,
  output logic [1:0]                     alu_src_b,
  output logic [1:0]                     result_src,
  output logic [ALU_CNTL_BITS_COUNT-1:0] alu_control,
  output logic [IMM_TYPE_BITS_COUNT-1:0] imm_type,
  output logic                           illegal_instr,
  output logic                           bus_error
`ifdef MULTICYCLE_CU_PERF_EN
  ,
  output logic [31:0]                    cycle_count,
  output logic [31:0]                    instret_count
`endif
);

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_t                           state_q, state_d;
  logic [TMO_W-1:0]                 tmo_q, tmo_d;
  logic                             illegal_q, illegal_d;
  logic                             bus_err_q, bus_err_d;
  logic [ALU_CNTL_BITS_COUNT-1:0]   alu_dec;
  logic                             br_taken, br_illegal;
  logic                             mem_wait, tmo_hit;

  alu_decoder u_alu_decoder (
    .opcode_bit5 (opcode[5]),
    .funct3      (funct3),
    .funct7_bit5 (funct7_bit5),
    .alu_control (alu_dec)
  );

  branch_resolver u_branch_resolver (
    .funct3    (funct3),
    .zero_flag (zero_flag),
    .lt_flag   (lt_flag),
    .ltu_flag  (ltu_flag),
    .taken     (br_taken),
    .illegal   (br_illegal)
  );

  // Outputs decode from the registered state only (plus the handshake in
  // FETCH and the branch decision), so an asynchronous reset of state_q
  // drops the memory request immediately.
  always_comb begin
    mem_req     = 1'b0;
    mem_write   = 1'b0;
    adr_src     = ADR_PC;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    reg_write   = 1'b0;
    alu_src_a   = SRC_A_PC;
    alu_src_b   = SRC_B_RS2;
    result_src  = RES_ALUOUT;
    alu_control = ALU_ADD;
    imm_type    = IMM_I;
    if (state_q != S_IDLE && state_q != S_FETCH && state_q != S_TRAP)
      imm_type = imm_type_of(opcode);
    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        adr_src = ADR_PC;
        if (mem_ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          alu_src_a  = SRC_A_PC;
          alu_src_b  = SRC_B_FOUR;
          result_src = RES_ALU;
        end
      end
      S_DECODE: begin
        alu_src_a = SRC_A_OLDPC;
        alu_src_b = SRC_B_IMM;
      end
      S_MEM_ADR, S_JALR: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
      end
      S_MEM_READ: begin
        mem_req = 1'b1;
        adr_src = ADR_ALUOUT;
      end
      S_MEM_WB: begin
        result_src = RES_RDATA;
        reg_write  = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = ADR_ALUOUT;
      end
      S_EXEC_R: begin
        alu_src_a   = SRC_A_RS1;
        alu_src_b   = SRC_B_RS2;
        alu_control = alu_dec;
      end
      S_EXEC_I: begin
        alu_src_a   = SRC_A_RS1;
        alu_src_b   = SRC_B_IMM;
        alu_control = alu_dec;
      end
      S_ALU_WB: begin
        result_src = RES_ALUOUT;
        reg_write  = 1'b1;
      end
      // PC takes the jump target held in ALUOut while the ALU forms the
      // link address (old PC + 4) for the following writeback.
      S_JAL: begin
        pc_write   = 1'b1;
        result_src = RES_ALUOUT;
        alu_src_a  = SRC_A_OLDPC;
        alu_src_b  = SRC_B_FOUR;
      end
      S_UPPER: begin
        alu_src_b = SRC_B_IMM;
        if (opcode == OPC_LUI) begin
          alu_src_a   = SRC_A_PC;
          alu_control = ALU_PASS_B;
        end else begin
          alu_src_a   = SRC_A_OLDPC;
          alu_control = ALU_ADD;
        end
      end
      S_BRANCH: begin
        alu_src_a   = SRC_A_RS1;
        alu_src_b   = SRC_B_RS2;
        alu_control = ALU_SUB;
        result_src  = RES_ALUOUT;
        pc_write    = br_taken & ~br_illegal;
      end
      default: ;
    endcase
  end

  assign mem_wait = mem_req & ~mem_ready;
  // The last allowed waiting cycle with ready still low trips the timeout;
  // ready on that same cycle takes the normal handshake path instead.
  assign tmo_hit  = (MEM_TIMEOUT > 0) && mem_wait && (tmo_q == TMO_LAST);

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    bus_err_d = bus_err_q;
    case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: begin
        if (mem_ready) begin
          state_d = S_DECODE;
        end else if (tmo_hit) begin
          state_d   = S_TRAP;
          bus_err_d = 1'b1;
        end
      end
      S_DECODE: begin
        case (opcode)
          OPC_LOAD, OPC_STORE: state_d = S_MEM_ADR;
          OPC_OP:              state_d = S_EXEC_R;
          OPC_OP_IMM:          state_d = S_EXEC_I;
          OPC_JAL:             state_d = S_JAL;
          OPC_JALR:            state_d = S_JALR;
          OPC_BRANCH:          state_d = S_BRANCH;
          OPC_LUI, OPC_AUIPC:  state_d = S_UPPER;
          default: begin
            state_d   = S_TRAP;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEM_ADR: state_d = (opcode == OPC_STORE) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ: begin
        if (mem_ready) begin
          state_d = S_MEM_WB;
        end else if (tmo_hit) begin
          state_d   = S_TRAP;
          bus_err_d = 1'b1;
        end
      end
      S_MEM_WB: state_d = S_FETCH;
      S_MEM_WRITE: begin
        if (mem_ready) begin
          state_d = S_FETCH;
        end else if (tmo_hit) begin
          state_d   = S_TRAP;
          bus_err_d = 1'b1;
        end
      end
      S_EXEC_R, S_EXEC_I, S_UPPER, S_JAL: state_d = S_ALU_WB;
      S_ALU_WB: state_d = S_FETCH;
      // ALUOut now holds rs1 + imm; reuse the JAL step for the PC write.
      S_JALR:   state_d = S_JAL;
      S_BRANCH: begin
        if (br_illegal) begin
          state_d   = S_TRAP;
          illegal_d = 1'b1;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_IDLE;
    endcase
  end

  // The wait counter only runs while a request stalls in the same state.
  always_comb begin
    tmo_d = '0;
    if ((MEM_TIMEOUT > 0) && mem_wait && (state_d == state_q))
      tmo_d = tmo_q + TMO_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      tmo_q     <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign illegal_instr = illegal_q;
  assign bus_error     = bus_err_q;

`ifdef MULTICYCLE_CU_PERF_EN
  logic [31:0] cycle_q, instret_q;
  logic        retire;

  // Any entry into FETCH other than from IDLE (or a FETCH stall) ends an instruction.
  assign retire = (state_d == S_FETCH) && (state_q != S_FETCH) && (state_q != S_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else if (state_q != S_TRAP) begin
      cycle_q <= cycle_q + 32'd1;
      if (retire)
        instret_q <= instret_q + 32'd1;
    end
  end

  assign cycle_count   = cycle_q;
  assign instret_count = instret_q;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit. The stimulus process drives
// the instruction fields and handshake, pushing the hand-derived expected
// control vector for each cycle into a queue; a monitor on the falling edge
// pops and compares against the DUT outputs.
module tb_multicycle_control_unit;
  import cu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7_bit5, zero_flag, lt_flag, ltu_flag, mem_ready;
  logic        mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
  logic [1:0]  alu_src_a, alu_src_b, result_src;
  logic [ALU_CNTL_BITS_COUNT-1:0] alu_control;
  logic [IMM_TYPE_BITS_COUNT-1:0] imm_type;
  logic        illegal_instr, bus_error;

  always #5 clk = ~clk;

  multicycle_control_unit #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3),
    .funct7_bit5(funct7_bit5), .zero_flag(zero_flag), .lt_flag(lt_flag),
    .ltu_flag(ltu_flag), .mem_ready(mem_ready), .mem_req(mem_req),
    .mem_write(mem_write), .adr_src(adr_src), .ir_write(ir_write),
    .pc_write(pc_write), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .result_src(result_src), .alu_control(alu_control),
    .imm_type(imm_type), .illegal_instr(illegal_instr), .bus_error(bus_error)
  );

  typedef struct packed {
    logic       req, wr, adr, irw, pcw, rgw;
    logic [1:0] sa, sb, rs;
    logic       ill, be;
  } ctl_t;

  typedef struct {
    string name;
    ctl_t  c;
    int    alu;   // -1 = not checked
    int    imm;   // -1 = not checked
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   errors = 0;

  function automatic ctl_t mk(input logic req, wr, adr, irw, pcw, rgw,
                              input logic [1:0] sa, sb, rs, input logic ill, be);
    ctl_t c;
    c.req = req; c.wr = wr; c.adr = adr; c.irw = irw; c.pcw = pcw; c.rgw = rgw;
    c.sa = sa; c.sb = sb; c.rs = rs; c.ill = ill; c.be = be;
    return c;
  endfunction

  // Frequently used expected vectors
  ctl_t Z, F_HS, F_W, DEC, WB, MADR, MRD, MWB, MWR, EXR, EXI;

  // Monitor
  exp_t e;
  ctl_t act;
  always @(negedge clk) begin
    if (expq.size() > 0) begin
      e = expq.pop_front();
      act = mk(mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
               alu_src_a, alu_src_b, result_src, illegal_instr, bus_error);
      checks++;
      if (act !== e.c) begin
        errors++;
        $display("FAIL %s: ctl got %b want %b (req wr adr irw pcw rgw sa sb rs ill be)",
                 e.name, act, e.c);
      end
      if (e.alu >= 0) begin
        checks++;
        if (alu_control !== ALU_CNTL_BITS_COUNT'(e.alu)) begin
          errors++;
          $display("FAIL %s_alu: alu_control got %0d want %0d", e.name, alu_control, e.alu);
        end
      end
      if (e.imm >= 0) begin
        checks++;
        if (imm_type !== IMM_TYPE_BITS_COUNT'(e.imm)) begin
          errors++;
          $display("FAIL %s_imm: imm_type got %0d want %0d", e.name, imm_type, e.imm);
        end
      end
    end
  end

  task automatic cyc(input string n, input ctl_t c, input int alu, input int imm);
    exp_t x;
    x.name = n; x.c = c; x.alu = alu; x.imm = imm;
    expq.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    cyc("rst_hold", Z, 0, 0);
    reset = 1'b0;
    cyc("idle", Z, 0, 0);
  endtask

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    opcode = op; funct3 = f3; funct7_bit5 = f7;
  endtask

  task automatic branch(input string n, input logic [2:0] f3, input logic z, lt, ltu,
                        input logic taken);
    set_instr(7'b1100011, f3, 1'b0);
    zero_flag = z; lt_flag = lt; ltu_flag = ltu; mem_ready = 1'b1;
    cyc({n, "_fetch"}, F_HS, 0, -1);
    cyc({n, "_dec"}, DEC, 0, 2);
    cyc({n, "_br"}, mk(0,0,0,0,taken,0,2'b10,2'b00,2'b00,0,0), 1, -1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Z    = '0;
    F_HS = mk(1,0,0,1,1,0,2'b00,2'b10,2'b10,0,0);
    F_W  = mk(1,0,0,0,0,0,2'b00,2'b00,2'b00,0,0);
    DEC  = mk(0,0,0,0,0,0,2'b01,2'b01,2'b00,0,0);
    WB   = mk(0,0,0,0,0,1,2'b00,2'b00,2'b00,0,0);
    MADR = mk(0,0,0,0,0,0,2'b10,2'b01,2'b00,0,0);
    MRD  = mk(1,0,1,0,0,0,2'b00,2'b00,2'b00,0,0);
    MWB  = mk(0,0,0,0,0,1,2'b00,2'b00,2'b01,0,0);
    MWR  = mk(1,1,1,0,0,0,2'b00,2'b00,2'b00,0,0);
    EXR  = mk(0,0,0,0,0,0,2'b10,2'b00,2'b00,0,0);
    EXI  = mk(0,0,0,0,0,0,2'b10,2'b01,2'b00,0,0);

    set_instr(7'b0, 3'b0, 1'b0);
    zero_flag = 0; lt_flag = 0; ltu_flag = 0;
    do_reset();

    // sub x, zero-wait: FETCH, DECODE, EXEC_R, ALU_WB
    set_instr(7'b0110011, 3'b000, 1'b1);
    cyc("sub_fetch", F_HS, 0, -1);
    cyc("sub_dec", DEC, 0, 0);
    cyc("sub_exec", EXR, 1, -1);
    cyc("sub_wb", WB, -1, -1);

    // addi with bit30 set still adds; srai with bit30 set is SRA
    set_instr(7'b0010011, 3'b000, 1'b1);
    cyc("addi_fetch", F_HS, 0, -1);
    cyc("addi_dec", DEC, 0, 0);
    cyc("addi_exec", EXI, 0, -1);
    cyc("addi_wb", WB, -1, -1);
    set_instr(7'b0010011, 3'b101, 1'b1);
    cyc("srai_fetch", F_HS, 0, -1);
    cyc("srai_dec", DEC, 0, 0);
    cyc("srai_exec", EXI, 7, -1);
    cyc("srai_wb", WB, -1, -1);

    // lw with 3 wait cycles in MEM_READ (ready on the 4th = timeout limit)
    set_instr(7'b0000011, 3'b010, 1'b0);
    cyc("lw_fetch", F_HS, 0, -1);
    cyc("lw_dec", DEC, 0, 0);
    cyc("lw_adr", MADR, 0, -1);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) cyc("lw_wait", MRD, -1, -1);
    mem_ready = 1'b1;
    cyc("lw_rd", MRD, -1, -1);
    cyc("lw_wb", MWB, -1, -1);

    // sw zero-wait
    set_instr(7'b0100011, 3'b010, 1'b0);
    cyc("sw_fetch", F_HS, 0, -1);
    cyc("sw_dec", DEC, 0, 1);
    cyc("sw_adr", MADR, 0, -1);
    cyc("sw_wr", MWR, -1, -1);

    // jal: PC write from ALUOut, ALU forms old PC + 4
    set_instr(7'b1101111, 3'b000, 1'b0);
    cyc("jal_fetch", F_HS, 0, -1);
    cyc("jal_dec", DEC, 0, 4);
    cyc("jal_jump", mk(0,0,0,0,1,0,2'b01,2'b10,2'b00,0,0), 0, -1);
    cyc("jal_wb", WB, -1, -1);

    // lui, fetch stalls 3 cycles then ready on the 4th: no bus error
    set_instr(7'b0110111, 3'b000, 1'b0);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) cyc("lui_fwait", F_W, -1, -1);
    mem_ready = 1'b1;
    cyc("lui_fetch", F_HS, 0, -1);
    cyc("lui_dec", DEC, 0, 3);
    cyc("lui_upper", mk(0,0,0,0,0,0,2'b00,2'b01,2'b00,0,0), 10, -1);
    cyc("lui_wb", WB, -1, -1);

    // branches
    branch("bge_nt_lt0", 3'b101, 1'b0, 1'b0, 1'b1, 1'b1);
    branch("bge_lt1",    3'b101, 1'b0, 1'b1, 1'b0, 1'b0);
    branch("beq_z1",     3'b000, 1'b1, 1'b0, 1'b0, 1'b1);
    branch("bne_z1",     3'b001, 1'b1, 1'b0, 1'b0, 1'b0);
    branch("bltu_ltu0",  3'b110, 1'b0, 1'b1, 1'b0, 1'b0);
    branch("bgeu_ltu0",  3'b111, 1'b0, 1'b1, 1'b0, 1'b1);

    // illegal branch funct3 -> TRAP with illegal_instr
    branch("b010", 3'b010, 1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc("b010_trap", mk(0,0,0,0,0,0,2'b00,2'b00,2'b00,1,0), 0, -1);
    do_reset();

    // opcode 0 -> TRAP from DECODE, illegal_instr sticky for 10 cycles
    set_instr(7'b0000000, 3'b000, 1'b0);
    cyc("op0_fetch", F_HS, 0, -1);
    cyc("op0_dec", DEC, 0, -1);
    for (int i = 0; i < 10; i++) begin
      mem_ready = i[0];
      cyc("op0_trap", mk(0,0,0,0,0,0,2'b00,2'b00,2'b00,1,0), 0, -1);
    end
    do_reset();

    // fetch timeout: 4 waiting cycles then TRAP with bus_error, no request
    set_instr(7'b0110011, 3'b000, 1'b0);
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) cyc("tmo_wait", F_W, -1, -1);
    for (int i = 0; i < 3; i++) cyc("tmo_trap", mk(0,0,0,0,0,0,2'b00,2'b00,2'b00,0,1), 0, -1);
    mem_ready = 1'b1;
    do_reset();

    // reset asserted mid MEM_WRITE drops request without a clock edge
    set_instr(7'b0100011, 3'b010, 1'b0);
    cyc("sw2_fetch", F_HS, 0, -1);
    cyc("sw2_dec", DEC, 0, 1);
    cyc("sw2_adr", MADR, 0, -1);
    mem_ready = 1'b0;
    cyc("sw2_wait", MWR, -1, -1);
    reset = 1'b1;
    cyc("rst_async", Z, 0, 0);
    reset = 1'b0;
    mem_ready = 1'b1;
    cyc("rst_idle", Z, 0, 0);
    cyc("rst_fetch", F_HS, 0, -1);

    @(negedge clk);
    #1;
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: %0d pending expectations, want 0", expq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
